if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC and drives the instruction-memory request/acknowledge handshake.
- Presents each fetched instruction with its PC to the IF/ID pipeline register.
- Honours hazard-unit stalls with a one-entry hold buffer and applies ID-resolved branch/jump redirects, preserving the MIPS branch delay slot.

---
 rtl/if_stage_if.sv | 9 +
 rtl/if_stage.sv | 97 +++++++++
 tb/tb_if_stage.sv | 135 +++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory request/acknowledge bus between the fetch stage and imem.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_stage.sv
// if_stage: MIPS fetch stage with PC, imem handshake, one-entry stall hold buffer and delay-slot-aware redirects.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  if_stage_if.master  imem,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);
  typedef enum logic {FETCH, HOLD} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, pc_slot_q, pc_slot_d, inst_q, inst_d;
  logic [31:0] hold_pc_q, hold_pc_d, hold_inst_q, hold_inst_d;
  logic [31:0] redir_tgt_q, redir_tgt_d, tgt;
  logic        valid_q, valid_d, redir_q, redir_d, ack, br;
  assign tgt = branch_target_i & ~32'h3;
  assign br  = branch_flag_i & ~stall_i;
  assign ack = imem.imem_req & imem.imem_ack;
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      pc_slot_q   <= '0;
      inst_q      <= '0;
      valid_q     <= 1'b0;
      hold_pc_q   <= '0;
      hold_inst_q <= '0;
      redir_q     <= 1'b0;
      redir_tgt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_slot_q   <= pc_slot_d;
      inst_q      <= inst_d;
      valid_q     <= valid_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
      redir_q     <= redir_d;
      redir_tgt_q <= redir_tgt_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_slot_d   = pc_slot_q;
    inst_d      = inst_q;
    valid_d     = valid_q;
    hold_pc_d   = hold_pc_q;
    hold_inst_d = hold_inst_q;
    redir_d     = redir_q;
    redir_tgt_d = redir_tgt_q;
    // Presented instruction is the delay slot: everything fetched behind it is wrong-path.
    if (br && valid_q) begin
      pc_d    = tgt;
      valid_d = 1'b0;
      state_d = FETCH;
    end else if (state_q == HOLD) begin
      if (!stall_i) begin
        pc_slot_d = hold_pc_q;
        inst_d    = hold_inst_q;
        valid_d   = 1'b1;
        state_d   = FETCH;
      end
    end else if (ack) begin
      pc_d    = redir_q ? redir_tgt_q : br ? tgt : pc_q + 32'd4;
      redir_d = 1'b0;
      if (stall_i && valid_q) begin
        hold_pc_d   = pc_q;
        hold_inst_d = imem.imem_rdata;
        state_d     = HOLD;
      end else begin
        pc_slot_d = pc_q;
        inst_d    = imem.imem_rdata;
        valid_d   = 1'b1;
      end
    end else begin
      // In-flight fetch is the delay slot; redirect once it returns.
      if (br) begin
        redir_d     = 1'b1;
        redir_tgt_d = tgt;
      end
      if (!stall_i) valid_d = 1'b0;
    end
  end
  always_comb begin
    imem.imem_req  = (state_q == FETCH) && !Rst;
    imem.imem_addr = pc_q;
    if_pc          = pc_slot_q;
    if_inst        = inst_q;
    if_valid       = valid_q;
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of fetch sequencing, latency, stall hold, redirects and reset.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        Rst, stall_i, branch_flag_i, if_valid, force_ack;
  logic [31:0] branch_target_i, if_pc, if_inst;
  int          lat, cnt = 0, total = 0, bad = 0;
  if_stage_if bus ();
  if_stage #(.RESET_PC(32'h0)) dut (
    .clk(clk), .Rst(Rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
    .branch_target_i(branch_target_i), .imem(bus), .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
  );
  always #5 clk = ~clk;
  always_comb begin
    bus.imem_ack   = force_ack | (bus.imem_req && (lat == 0 || cnt == lat - 1));
    bus.imem_rdata = bus.imem_addr ^ 32'hA5A5A5A5;
  end
  always @(posedge clk) cnt <= (!bus.imem_req || bus.imem_ack) ? 0 : cnt + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    Rst = 1; stall_i = 0; branch_flag_i = 0; branch_target_i = 0; lat = 0; force_ack = 0;
    cyc; cyc;
    Rst = 0;
    #1;
  endtask
  initial begin
    Rst = 1; stall_i = 0; branch_flag_i = 0; branch_target_i = 0; lat = 0; force_ack = 0;
    cyc; cyc;
    chk("rst_valid", 32'(if_valid), 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_inst", if_inst, 0);
    chk("rst_req", 32'(bus.imem_req), 0);
    Rst = 0;
    #1;
    chk("first_addr", bus.imem_addr, 0);
    chk("first_req", 32'(bus.imem_req), 1);
    for (int i = 0; i < 4; i++) begin
      cyc;
      chk("seq_pc", if_pc, 32'(i * 4));
      chk("seq_valid", 32'(if_valid), 1);
      chk("seq_inst", if_inst, 32'(i * 4) ^ 32'hA5A5A5A5);
    end
    lat = 3;
    for (int k = 0; k < 2; k++) begin
      cyc;
      chk("lat_v0a", 32'(if_valid), 0);
      chk("lat_addr_a", bus.imem_addr, 32'h10 + 32'(k * 4));
      cyc;
      chk("lat_v0b", 32'(if_valid), 0);
      chk("lat_addr_b", bus.imem_addr, 32'h10 + 32'(k * 4));
      cyc;
      chk("lat_v1", 32'(if_valid), 1);
      chk("lat_pc", if_pc, 32'h10 + 32'(k * 4));
    end
    do_reset;
    repeat (3) cyc;
    chk("st_pc0", if_pc, 32'h8);
    stall_i = 1;
    for (int i = 0; i < 4; i++) begin
      cyc;
      chk("st_pc", if_pc, 32'h8);
      chk("st_valid", 32'(if_valid), 1);
      chk("st_req", 32'(bus.imem_req), 0);
      if (i == 3) stall_i = 0;
    end
    cyc;
    chk("st_rel_pc", if_pc, 32'hC);
    chk("st_rel_inst", if_inst, 32'hC ^ 32'hA5A5A5A5);
    chk("st_rel_addr", bus.imem_addr, 32'h10);
    chk("st_rel_req", 32'(bus.imem_req), 1);
    cyc;
    chk("st_next_pc", if_pc, 32'h10);
    do_reset;
    repeat (9) cyc;
    chk("ba_pc0", if_pc, 32'h20);
    branch_flag_i = 1; branch_target_i = 32'h102;
    cyc;
    branch_flag_i = 0;
    chk("ba_drop", 32'(if_valid), 0);
    chk("ba_addr", bus.imem_addr, 32'h100);
    cyc;
    chk("ba_pc", if_pc, 32'h100);
    chk("ba_valid", 32'(if_valid), 1);
    branch_flag_i = 1; branch_target_i = 32'hFFFF_FFF8;
    cyc;
    branch_flag_i = 0;
    chk("wr_addr", bus.imem_addr, 32'hFFFF_FFF8);
    cyc;
    chk("wr_pc0", if_pc, 32'hFFFF_FFF8);
    cyc;
    chk("wr_pc1", if_pc, 32'hFFFF_FFFC);
    cyc;
    chk("wr_pc2", if_pc, 32'h0);
    do_reset;
    repeat (9) cyc;
    chk("bb_pc0", if_pc, 32'h20);
    lat = 3;
    cyc;
    chk("bb_v0", 32'(if_valid), 0);
    chk("bb_addr0", bus.imem_addr, 32'h24);
    branch_flag_i = 1; branch_target_i = 32'h200;
    cyc;
    branch_flag_i = 0;
    chk("bb_addr1", bus.imem_addr, 32'h24);
    chk("bb_v1", 32'(if_valid), 0);
    cyc;
    chk("bb_pc", if_pc, 32'h24);
    chk("bb_valid", 32'(if_valid), 1);
    chk("bb_addr2", bus.imem_addr, 32'h200);
    cyc;
    Rst = 1; force_ack = 1;
    cyc;
    chk("rr_req", 32'(bus.imem_req), 0);
    chk("rr_valid", 32'(if_valid), 0);
    chk("rr_pc", if_pc, 0);
    Rst = 0; force_ack = 0; lat = 0;
    #1;
    chk("rr_addr", bus.imem_addr, 0);
    chk("rr_req1", 32'(bus.imem_req), 1);
    cyc;
    chk("rr_first_pc", if_pc, 0);
    chk("rr_first_valid", 32'(if_valid), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
